// File: rtl/hsys_mem_stream_writer.sv
// Stream-to-memory fill stage: packs 32-bit beats little-endian into 64-bit
// single-cycle writes at consecutive addresses, sequenced by start/busy/done.
module hsys_mem_stream_writer #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    input  logic [31:0]       sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [63:0]       mem_writedata
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [31:0]       pack_q, pack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sink_ready_q, sink_ready_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [7:0]        mem_byteenable_q, mem_byteenable_d;
    logic              mem_write_q, mem_write_d;
    logic [63:0]       mem_writedata_q, mem_writedata_d;
    logic              beat;

    // Handshake: a beat transfers on the clock edge where sink_valid and sink_ready
    // are both high; sink_ready is a flop driven from state only, never from sink_valid.
    assign beat = sink_valid & sink_ready_q;

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remaining_d      = remaining_q;
        pack_d           = pack_q;
        done_d           = 1'b0;
        mem_address_d    = mem_address_q;
        mem_byteenable_d = 8'h00;
        mem_write_d      = 1'b0;
        mem_writedata_d  = mem_writedata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = num_words;
                    state_d     = (num_words != '0) ? S_LO : S_FIN;
                end
            end
            S_LO: begin
                if (beat) begin
                    pack_d      = sink_data;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        mem_write_d      = 1'b1;
                        mem_byteenable_d = 8'h0F;
                        mem_writedata_d  = {32'h0, sink_data};
                        mem_address_d    = addr_q;
                        addr_d           = addr_q + ADDR_W'(1);
                        state_d          = S_FIN;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (beat) begin
                    remaining_d      = remaining_q - LEN_W'(1);
                    mem_write_d      = 1'b1;
                    mem_byteenable_d = 8'hFF;
                    mem_writedata_d  = {sink_data, pack_q};
                    mem_address_d    = addr_q;
                    addr_d           = addr_q + ADDR_W'(1);
                    state_d          = (remaining_q == LEN_W'(1)) ? S_FIN : S_LO;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d != S_IDLE);
        sink_ready_d = (state_d == S_LO) || (state_d == S_HI);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            addr_q           <= '0;
            remaining_q      <= '0;
            pack_q           <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            sink_ready_q     <= 1'b0;
            mem_address_q    <= '0;
            mem_byteenable_q <= 8'h00;
            mem_write_q      <= 1'b0;
            mem_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            remaining_q      <= remaining_d;
            pack_q           <= pack_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            sink_ready_q     <= sink_ready_d;
            mem_address_q    <= mem_address_d;
            mem_byteenable_q <= mem_byteenable_d;
            mem_write_q      <= mem_write_d;
            mem_writedata_q  <= mem_writedata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign sink_ready     = sink_ready_q;
    assign mem_address    = mem_address_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_chipselect = mem_write_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_writedata_q;

endmodule

// File: tb/tb_hsys_mem_stream_writer.sv
// Bench for hsys_mem_stream_writer: table of directed transfers, randomized
// transfers, and a reset-abort sequence, all checked against a packing model.
module tb_hsys_mem_stream_writer;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [11:0] num_words;
    logic        busy;
    logic        done;
    logic [31:0] sink_data;
    logic        sink_valid;
    logic        sink_ready;
    logic [9:0]  mem_address;
    logic [7:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [63:0] mem_writedata;

    hsys_mem_stream_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .busy           (busy),
        .done           (done),
        .sink_data      (sink_data),
        .sink_valid     (sink_valid),
        .sink_ready     (sink_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] base;
        int         n;
        int         first_mult;
        bit         rnd_valid;
        bit         mid_start;
        int         exp_writes;
    } xfer_t;

    xfer_t       tbl [4];
    logic [31:0] words [0:63];
    logic [81:0] exp_q [$];
    int          n_vec;
    int          n_err;
    int          wr_cnt;
    int          done_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then check the memory port against the scoreboard.
    task automatic tick();
        logic [81:0] e;
        @(negedge clk);
        if (mem_write === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         mem_address, mem_writedata);
            end else begin
                e = exp_q.pop_front();
                chk("write", {mem_chipselect, mem_address, mem_byteenable, mem_writedata},
                    {1'b1, e});
            end
        end else begin
            chk("idle_port", {mem_chipselect, mem_byteenable}, 9'h0);
        end
        if (done === 1'b1) done_cnt++;
    endtask

    // Reference model: word pairs packed little-endian, odd tail zero-padded, addresses wrap at 1024.
    task automatic push_expected(input int base, input int n);
        for (int k = 0; 2 * k < n; k++) begin
            logic [31:0] lo;
            logic [31:0] hi;
            logic [7:0]  be;
            int          a;
            lo = words[2 * k];
            if (2 * k + 1 < n) begin
                hi = words[2 * k + 1];
                be = 8'hFF;
            end else begin
                hi = 32'h0;
                be = 8'h0F;
            end
            a = (base + k) % 1024;
            exp_q.push_back({a[9:0], be, hi, lo});
        end
    endtask

    task automatic fill_words(input int first_mult);
        for (int i = 0; i < 64; i++) begin
            if (first_mult != 0) words[i] = 32'((first_mult + i) * 32'h11111111);
            else words[i] = $urandom;
        end
    endtask

    task automatic run_xfer(input logic [9:0] base, input int n, input bit rnd_valid,
                            input bit mid_start, input int exp_writes);
        int wr0;
        int d0;
        int idx;
        int it;
        bit acc;
        wr0 = wr_cnt;
        d0  = done_cnt;
        push_expected(base, n);
        chk("busy_before_start", busy, 1'b0);
        start     = 1'b1;
        base_addr = base;
        num_words = 12'(n);
        tick();
        start     = 1'b0;
        base_addr = 10'($urandom);
        num_words = 12'($urandom_range(1, 40));
        chk("busy_after_start", {busy, done}, 2'b10);
        idx = 0;
        it  = 0;
        while (idx < n && it < 400) begin
            sink_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            sink_data  = sink_valid ? words[idx] : 32'($urandom);
            if (mid_start && it == 3) begin
                start     = 1'b1;
                base_addr = 10'($urandom);
                num_words = 12'($urandom_range(1, 40));
            end else begin
                start = 1'b0;
            end
            acc = sink_valid && (sink_ready === 1'b1);
            tick();
            if (acc) idx++;
            it++;
        end
        start = 1'b0;
        if (it >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: got %0d beats accepted expected %0d", idx, n);
        end
        sink_valid = 1'($urandom_range(0, 1));
        sink_data  = 32'($urandom);
        if (n != 0) chk("final_write_cycle", mem_write, 1'b1);
        chk("fin_cycle_busy_done", {busy, done}, 2'b10);
        tick();
        chk("done_cycle", {busy, done, sink_ready}, 3'b010);
        sink_valid = 1'b0;
        tick();
        tick();
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("write_count", 32'(wr_cnt - wr0), 32'(exp_writes));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int wr0;
        int d0;
        int idx;
        int it;
        n_vec      = 0;
        n_err      = 0;
        wr_cnt     = 0;
        done_cnt   = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_words  = '0;
        sink_data  = '0;
        sink_valid = 1'b0;

        tbl[0] = '{10'h010, 4, 1, 1'b0, 1'b0, 2};
        tbl[1] = '{10'h3FF, 3, 10, 1'b0, 1'b0, 2};
        tbl[2] = '{10'h123, 0, 1, 1'b0, 1'b0, 0};
        tbl[3] = '{10'h100, 6, 5, 1'b1, 1'b1, 3};

        tick();
        tick();
        chk("reset_outputs", {busy, done, sink_ready, mem_write, mem_chipselect,
                              mem_byteenable, mem_address, mem_writedata}, 128'h0);
        reset_n    = 1'b1;
        sink_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sink_data = 32'($urandom);
            tick();
            chk("idle_outputs", {busy, done, sink_ready, mem_write, mem_chipselect,
                                 mem_byteenable, mem_address, mem_writedata}, 128'h0);
        end
        sink_valid = 1'b0;

        for (int r = 0; r < 4; r++) begin
            fill_words(tbl[r].first_mult);
            run_xfer(tbl[r].base, tbl[r].n, tbl[r].rnd_valid, tbl[r].mid_start, tbl[r].exp_writes);
        end

        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(0, 25);
            fill_words(0);
            run_xfer(10'($urandom), n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     (n + 1) / 2);
        end

        // Reset after three accepted beats: only the first pair is written, the held low half is lost.
        fill_words(0);
        wr0 = wr_cnt;
        d0  = done_cnt;
        push_expected(10'h2A0, 2);
        start     = 1'b1;
        base_addr = 10'h2A0;
        num_words = 12'd8;
        tick();
        start = 1'b0;
        idx   = 0;
        it    = 0;
        while (idx < 3 && it < 50) begin
            sink_valid = 1'b1;
            sink_data  = words[idx];
            if (sink_ready === 1'b1) begin
                tick();
                idx++;
            end else begin
                tick();
            end
            it++;
        end
        reset_n    = 1'b0;
        sink_data  = words[3];
        tick();
        reset_n = 1'b1;
        chk("post_reset_state", {busy, done, sink_ready, mem_write}, 4'b0000);
        for (int i = 0; i < 6; i++) tick();
        sink_valid = 1'b0;
        chk("abort_done_count", 32'(done_cnt - d0), 32'd0);
        chk("abort_write_count", 32'(wr_cnt - wr0), 32'd1);
        chk("abort_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        fill_words(7);
        run_xfer(10'h055, 2, 1'b0, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
